csr_access_sequencer: RTL

- Sits directly upstream of the M-mode CSR file and exception handler, between the Lagarto Hun execute stage and the CSR port.
- Accepts one decoded Zicsr instruction at a time: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI.
- Sequences the read-modify-write as separate read and write cycles on the CSR port, computes the new value, and flags illegal accesses.
- Returns old CSR value or illegal flag to the core over a valid/ready response channel.

---
 rtl/csr_access_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/csr_access_sequencer.sv
// Zicsr read-modify-write sequencer between the execute stage and the M-mode CSR file.
// Splits each CSR instruction into separate READ and WRITE port cycles and reports old value / illegal.

package csr_access_sequencer_pkg;

    typedef enum logic [1:0] {
        NO_COMMAND = 2'b00,
        READ_ONLY  = 2'b01,
        WRITE_ONLY = 2'b10
    } csr_command_t;

endpackage

module csr_access_sequencer
    import csr_access_sequencer_pkg::*;
#(
    parameter int MXLEN = 64
) (
    input  logic               clock_i,
    input  logic               reset_i,

    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [2:0]         req_funct3_i,
    input  logic [11:0]        req_address_i,
    input  logic [4:0]         req_rs1_idx_i,
    input  logic [MXLEN-1:0]   req_rs1_data_i,
    input  logic [4:0]         req_rd_idx_i,

    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MXLEN-1:0]   rsp_read_data_o,
    output logic               rsp_illegal_o,

    output logic [11:0]        csr_address_o,
    output csr_command_t       csr_command_o,
    output logic [MXLEN-1:0]   csr_write_data_o,
    input  logic [MXLEN-1:0]   csr_read_data_i,
    input  logic               csr_read_data_valid_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

    // funct3[1:0]; 00 is not a Zicsr operation and is caught as illegal on accept.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_W    = 2'b01,
        OP_S    = 2'b10,
        OP_C    = 2'b11
    } op_t;

    state_t             state_q, state_d;

    logic [11:0]        address_q;
    op_t                op_q;
    logic [MXLEN-1:0]   src_q;
    logic               do_write_q;
    logic               do_read_q;
    logic               illegal_q;
    logic [MXLEN-1:0]   old_q;
    logic [MXLEN-1:0]   new_q;

    // Request decode, evaluated while IDLE so the accept edge can latch the results.
    op_t                req_op;
    logic [MXLEN-1:0]   req_src;
    logic               req_do_write;
    logic               req_do_read;
    logic               req_illegal;
    logic               accept;

    always_comb begin
        req_op       = op_t'(req_funct3_i[1:0]);
        req_src      = req_funct3_i[2] ? {{(MXLEN-5){1'b0}}, req_rs1_idx_i} : req_rs1_data_i;
        req_do_write = (req_op == OP_W) || (req_rs1_idx_i != 5'd0);
        req_do_read  = (req_op != OP_W) || (req_rd_idx_i != 5'd0);
        req_illegal  = (req_op == OP_NONE)
                    || (req_do_write && (req_address_i[11:10] == 2'b11));
        accept       = (state_q == IDLE) && req_valid_i;
    end

    // Read-phase datapath: a skipped read behaves as if the CSR held zero.
    logic [MXLEN-1:0]   read_old;
    logic [MXLEN-1:0]   read_new;

    always_comb begin
        read_old = do_read_q ? csr_read_data_i : '0;
        case (op_q)
            OP_W:    read_new = src_q;
            OP_S:    read_new = read_old | src_q;
            OP_C:    read_new = read_old & ~src_q;
            default: read_new = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: datapath registers are reset too, so a dropped operation leaves nothing stale behind.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            address_q  <= '0;
            op_q       <= OP_NONE;
            src_q      <= '0;
            do_write_q <= 1'b0;
            do_read_q  <= 1'b0;
            illegal_q  <= 1'b0;
            old_q      <= '0;
            new_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        address_q  <= req_address_i;
                        op_q       <= req_op;
                        src_q      <= req_src;
                        do_write_q <= req_do_write;
                        do_read_q  <= req_do_read;
                        illegal_q  <= req_illegal;
                        old_q      <= '0;
                        new_q      <= '0;
                    end
                end
                READ: begin
                    if (!csr_read_data_valid_i) begin
                        illegal_q <= 1'b1;
                        old_q     <= '0;
                        new_q     <= '0;
                    end else begin
                        old_q     <= read_old;
                        new_q     <= read_new;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        rsp_valid_o      = 1'b0;
        rsp_read_data_o  = '0;
        rsp_illegal_o    = 1'b0;
        csr_address_o    = '0;
        csr_command_o    = NO_COMMAND;
        csr_write_data_o = '0;

        // Outputs stay at their idle values while reset is held, whatever the state.
        if (!reset_i) begin
            case (state_q)
                IDLE: begin
                    req_ready_o = 1'b1;
                    if (req_valid_i) begin
                        state_d = req_illegal ? RESP : READ;
                    end
                end
                READ: begin
                    csr_address_o = address_q;
                    csr_command_o = do_read_q ? READ_ONLY : NO_COMMAND;
                    if (!csr_read_data_valid_i) begin
                        state_d = RESP;
                    end else if (do_write_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RESP;
                    end
                end
                WRITE: begin
                    csr_address_o    = address_q;
                    csr_command_o    = WRITE_ONLY;
                    csr_write_data_o = new_q;
                    state_d          = RESP;
                end
                RESP: begin
                    rsp_valid_o     = 1'b1;
                    rsp_read_data_o = old_q;
                    rsp_illegal_o   = illegal_q;
                    if (rsp_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
